// File: rtl/fb_writer_nto1_pkg.sv
// Shared constants and helpers for the N-to-1 frame-buffer writer.
package fb_writer_nto1_pkg;

  localparam int unsigned BRESP_WIDTH = 2;

  localparam logic [0:0] FBW_IDLE = 1'b0;
  localparam logic [0:0] FBW_RESP = 1'b1;

  function automatic int unsigned strb_width(input int unsigned data_width);
    return (data_width + 7) / 8;
  endfunction

endpackage

// File: rtl/fb_writer_nto1_fb_writer.sv
// Single-pixel AXI-lite writer: one AW + one W per accepted beat, then waits for B.
module fb_writer_nto1_fb_writer
  import fb_writer_nto1_pkg::*;
#(
  parameter int PIXEL_BITS     = 12,
  parameter int AXI_ADDR_WIDTH = 20,
  parameter int AXI_DATA_WIDTH = 16
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    tvalid,
  output logic                                    tready,
  input  logic [AXI_ADDR_WIDTH-1:0]               addr,
  input  logic [PIXEL_BITS-1:0]                   color,
  output logic [AXI_ADDR_WIDTH-1:0]               axi_awaddr,
  output logic                                    axi_awvalid,
  input  logic                                    axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]               axi_wdata,
  output logic [strb_width(AXI_DATA_WIDTH)-1:0]   axi_wstrb,
  output logic                                    axi_wvalid,
  input  logic                                    axi_wready,
  input  logic                                    axi_bvalid,
  output logic                                    axi_bready,
  input  logic [BRESP_WIDTH-1:0]                  axi_bresp
);

  logic [0:0] state;
  logic       idle;
  logic       aw_done;
  logic       w_done;
  logic       aw_ok;
  logic       w_ok;
  logic       unused_bresp;

  assign idle         = (state == FBW_IDLE);
  assign axi_awaddr   = addr;
  assign axi_wdata    = AXI_DATA_WIDTH'(color);
  assign axi_wstrb    = '1;
  assign axi_awvalid  = idle && tvalid && !aw_done;
  assign axi_wvalid   = idle && tvalid && !w_done;
  assign axi_bready   = !idle;
  assign aw_ok        = aw_done || axi_awready;
  assign w_ok         = w_done || axi_wready;
  // The beat is consumed only in the cycle both channels have been taken.
  assign tready       = idle && tvalid && aw_ok && w_ok;
  assign unused_bresp = ^axi_bresp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FBW_IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        FBW_IDLE: begin
          if (tready) begin
            state   <= FBW_RESP;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            if (axi_awvalid && axi_awready) aw_done <= 1'b1;
            if (axi_wvalid && axi_wready)   w_done  <= 1'b1;
          end
        end
        default: begin
          if (axi_bvalid) state <= FBW_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/fb_writer_nto1.sv
// Round-robin arbiter with bounded bursts feeding one frame-buffer writer.
module fb_writer_nto1
  import fb_writer_nto1_pkg::*;
#(
  parameter int NUM_INPUTS     = 4,
  parameter int PIXEL_BITS     = 12,
  parameter int AXI_ADDR_WIDTH = 20,
  parameter int AXI_DATA_WIDTH = 16,
  parameter int MAX_BURST      = 4
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_INPUTS-1:0]                   in_axi_tvalid,
  output logic [NUM_INPUTS-1:0]                   in_axi_tready,
  input  logic [NUM_INPUTS*AXI_ADDR_WIDTH-1:0]    in_addr,
  input  logic [NUM_INPUTS*PIXEL_BITS-1:0]        in_color,
  output logic                                    grant_valid,
  output logic [$clog2(NUM_INPUTS)-1:0]           grant_idx,
  output logic [AXI_ADDR_WIDTH-1:0]               axi_awaddr,
  output logic                                    axi_awvalid,
  input  logic                                    axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]               axi_wdata,
  output logic [strb_width(AXI_DATA_WIDTH)-1:0]   axi_wstrb,
  output logic                                    axi_wvalid,
  input  logic                                    axi_wready,
  input  logic                                    axi_bvalid,
  output logic                                    axi_bready,
  input  logic [BRESP_WIDTH-1:0]                  axi_bresp
);

  localparam int          IW          = $clog2(NUM_INPUTS);
  localparam int          BCW         = $clog2(MAX_BURST + 1);
  localparam int unsigned N           = NUM_INPUTS;
  localparam logic [BCW-1:0] BURST_LIMIT = BCW'(MAX_BURST);
  localparam logic [IW-1:0]  LAST_INIT   = IW'(NUM_INPUTS - 1);

  logic [AXI_ADDR_WIDTH-1:0] addr_arr  [NUM_INPUTS];
  logic [PIXEL_BITS-1:0]     color_arr [NUM_INPUTS];

  logic [IW-1:0]  last_idx;
  logic [IW-1:0]  rr_idx;
  logic           rr_found;
  logic [BCW-1:0] burst_cnt;
  logic [BCW-1:0] burst_next;
  logic           mux_tvalid;
  logic           fbw_tready;
  logic           beat;
  logic           stall;
  logic           keep;
  int unsigned    cand;

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_unpack
    assign addr_arr[g]  = in_addr[g*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
    assign color_arr[g] = in_color[g*PIXEL_BITS +: PIXEL_BITS];
  end

  assign mux_tvalid = grant_valid && in_axi_tvalid[grant_idx];
  assign stall      = mux_tvalid && !fbw_tready;
  assign beat       = mux_tvalid && fbw_tready;
  assign burst_next = burst_cnt + 1'b1;
  assign keep       = beat && (burst_next < BURST_LIMIT);

  // First valid requester after last_idx, wrapping; last_idx itself is tried last.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = (32'(last_idx) + k) % N;
      if (!rr_found && in_axi_tvalid[cand[IW-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    in_axi_tready = '0;
    if (grant_valid && fbw_tready) in_axi_tready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      last_idx    <= LAST_INIT;
      burst_cnt   <= '0;
    end else if (!stall) begin
      if (keep) begin
        burst_cnt <= burst_next;
      end else begin
        grant_valid <= rr_found;
        burst_cnt   <= '0;
        if (rr_found) begin
          grant_idx <= rr_idx;
          last_idx  <= rr_idx;
        end
      end
    end
  end

  fb_writer_nto1_fb_writer #(
    .PIXEL_BITS     (PIXEL_BITS),
    .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
    .AXI_DATA_WIDTH (AXI_DATA_WIDTH)
  ) u_fb_writer (
    .clk         (clk),
    .reset       (reset),
    .tvalid      (mux_tvalid),
    .tready      (fbw_tready),
    .addr        (addr_arr[grant_idx]),
    .color       (color_arr[grant_idx]),
    .axi_awaddr  (axi_awaddr),
    .axi_awvalid (axi_awvalid),
    .axi_awready (axi_awready),
    .axi_wdata   (axi_wdata),
    .axi_wstrb   (axi_wstrb),
    .axi_wvalid  (axi_wvalid),
    .axi_wready  (axi_wready),
    .axi_bvalid  (axi_bvalid),
    .axi_bready  (axi_bready),
    .axi_bresp   (axi_bresp)
  );

endmodule
